// File: rtl/fetch_line_unpacker_if.sv
// Line and instruction channels between the I-cache, the unpacker and decode.
// The slave modport is the unpacker's view; master is the surrounding fetch/decode logic.
interface fetch_line_unpacker_if #(
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int LINE_INSTR = 32
);
  logic                       line_valid;
  logic                       line_ready;
  logic [XLEN-1:0]            line_pc;
  logic [LINE_INSTR*ILEN-1:0] line;
  logic                       instr_valid;
  logic                       instr_ready;
  logic [ILEN-1:0]            instr;
  logic [XLEN-1:0]            pc;
  logic                       redirect;
  logic [XLEN-1:0]            redirect_pc;
  logic                       stale;
  logic [XLEN-1:0]            exp_pc;

  modport master (
    output line_valid, line_pc, line, instr_ready, redirect, redirect_pc,
    input  line_ready, instr_valid, instr, pc, stale, exp_pc
  );

  modport slave (
    input  line_valid, line_pc, line, instr_ready, redirect, redirect_pc,
    output line_ready, instr_valid, instr, pc, stale, exp_pc
  );
endinterface

// File: rtl/fetch_line_unpacker.sv
// Accepts whole I-cache lines and streams them to decode one instruction per cycle,
// dropping lines whose base does not match the expected fetch address.
module fetch_line_unpacker #(
  parameter int              XLEN       = 64,
  parameter int              ILEN       = 32,
  parameter int              LINE_INSTR = 32,
  parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fetch_line_unpacker_if.slave bus
);
  localparam int IDXW = $clog2(LINE_INSTR);
  localparam int LOW  = IDXW + 2;

  localparam logic [XLEN-1:0] LINE_BYTES = XLEN'(LINE_INSTR * 4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-LOW){1'b1}}, {LOW{1'b0}}};
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(LINE_INSTR - 1);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef logic [LINE_INSTR-1:0][ILEN-1:0] line_t;

  logic [0:0]      state_q, state_d;
  line_t           line_q, line_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] exp_q, exp_d;
  logic [IDXW-1:0] start_q, start_d;
  logic            stale_q, stale_d;

  logic            is_last;
  logic            instr_valid;
  logic            line_ready;
  logic            line_accept;
  logic            instr_hs;
  logic [XLEN-1:0] next_base;
  logic [XLEN-1:0] exp_cmp;
  logic            line_match;

  assign is_last     = (idx_q == LAST_IDX);
  assign instr_valid = (state_q == ST_ACTIVE) && !bus.redirect;
  assign line_ready  = (state_q == ST_EMPTY) || bus.redirect || (is_last && bus.instr_ready);
  assign line_accept = bus.line_valid && line_ready;
  assign instr_hs    = instr_valid && bus.instr_ready;
  assign next_base   = base_q + LINE_BYTES;

  // A line accepted while the last instruction leaves must match the line that follows it.
  assign exp_cmp    = (state_q == ST_ACTIVE) ? next_base : exp_q;
  assign line_match = (bus.line_pc[XLEN-1:LOW] == exp_cmp[XLEN-1:LOW]);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    line_d  = line_q;
    base_d  = base_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    start_d = start_q;
    stale_d = 1'b0;

    if (bus.redirect) begin
      state_d = ST_EMPTY;
      exp_d   = bus.redirect_pc & ALIGN_MASK;
      start_d = bus.redirect_pc[LOW-1:2];
    end else if (state_q == ST_EMPTY) begin
      if (line_accept) begin
        if (line_match) begin
          line_d  = line_t'(bus.line);
          base_d  = exp_q;
          idx_d   = start_q;
          state_d = ST_ACTIVE;
        end else begin
          stale_d = 1'b1;
        end
      end
    end else if (instr_hs) begin
      if (!is_last) begin
        idx_d = idx_q + IDXW'(1);
      end else begin
        exp_d   = next_base;
        start_d = '0;
        state_d = ST_EMPTY;
        if (line_accept) begin
          if (line_match) begin
            line_d  = line_t'(bus.line);
            base_d  = next_base;
            idx_d   = '0;
            state_d = ST_ACTIVE;
          end else begin
            stale_d = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      exp_q   <= BOOT_PC & ALIGN_MASK;
      start_q <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      start_q <= start_d;
      stale_q <= stale_d;
    end
  end

  // NOTE: the line buffer and its base are qualified by state_q, so they carry no reset.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
    base_q <= base_d;
  end

  assign bus.line_ready  = line_ready;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = line_q[idx_q];
  assign bus.pc          = base_q + XLEN'({idx_q, 2'b00});
  assign bus.stale       = stale_q;
  assign bus.exp_pc      = exp_q;

  // Offset bits below the line (and below the instruction) are don't-cares.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.line_pc[LOW-1:0], bus.redirect_pc[1:0]};
endmodule

// File: tb/tb_fetch_line_unpacker.sv
// Directed bench for fetch_line_unpacker: stimulus pushes expected instructions into a
// scoreboard queue, an independent monitor pops and compares every decode handshake.
module tb_fetch_line_unpacker;
  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int LINE_INSTR = 32;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  fetch_line_unpacker_if #(.XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LINE_INSTR)) bus ();

  fetch_line_unpacker #(
    .XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LINE_INSTR), .BOOT_PC(64'h0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [LINE_INSTR*ILEN-1:0] mk_line(input logic [ILEN-1:0] v);
    logic [LINE_INSTR*ILEN-1:0] l;
    for (int k = 0; k < LINE_INSTR; k++) l[k*ILEN +: ILEN] = v + ILEN'(k);
    return l;
  endfunction

  task automatic offer(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] v);
    bus.line_valid = 1'b1;
    bus.line_pc    = pc;
    bus.line       = mk_line(v);
  endtask

  task automatic push_line(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] v,
                           input int from, input int to);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.instr = v + ILEN'(k);
      e.pc    = pc + XLEN'(4 * k);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every completed decode handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (bus.instr_valid && bus.instr_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %h instr %h with empty scoreboard", bus.pc, bus.instr);
        end else begin
          e = sb_q.pop_front();
          check("mon_instr", 64'(bus.instr), 64'(e.instr));
          check("mon_pc", bus.pc, e.pc);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst             = 1'b1;
    bus.line_valid  = 1'b0;
    bus.line_pc     = '0;
    bus.line        = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset state
    tick(2); #3;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_stale", 64'(bus.stale), 64'd0);
    check("rst_ready", 64'(bus.line_ready), 64'd1);
    check("rst_exp", bus.exp_pc, 64'h0);

    // Line 0x0, decode always ready
    tick(1);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    offer(64'h0, 32'h1000);
    push_line(64'h0, 32'h1000, 0, 31);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("first_latency_valid", 64'(bus.instr_valid), 64'd1);
    check("first_latency_pc", bus.pc, 64'h0);

    // Back-to-back line 0x80 offered during the last instruction of line 0x0
    tick(31);
    offer(64'h80, 32'h2000);
    push_line(64'h80, 32'h2000, 0, 31);
    #3;
    check("b2b_last_pc", bus.pc, 64'h7C);
    check("b2b_ready", 64'(bus.line_ready), 64'd1);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("no_bubble_pc", bus.pc, 64'h80);
    check("b2b_exp", bus.exp_pc, 64'h80);
    tick(32); #3;
    check("drain_valid", 64'(bus.instr_valid), 64'd0);
    check("drain_exp", bus.exp_pc, 64'h100);

    // Stale drop: expect 0x80, offer 0x200
    tick(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h80;
    tick(1);
    bus.redirect = 1'b0;
    offer(64'h200, 32'hDEAD_0000);
    #3;
    check("stale_setup_exp", bus.exp_pc, 64'h80);
    check("stale_ready", 64'(bus.line_ready), 64'd1);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("stale_pulse", 64'(bus.stale), 64'd1);
    check("stale_no_instr", 64'(bus.instr_valid), 64'd0);
    tick(1); #3;
    check("stale_clear", 64'(bus.stale), 64'd0);
    check("stale_empty", 64'(bus.instr_valid), 64'd0);
    check("stale_exp", bus.exp_pc, 64'h80);

    // Redirect at idx 5 of line 0x80
    offer(64'h80, 32'h3000);
    push_line(64'h80, 32'h3000, 0, 4);
    tick(1);
    bus.line_valid = 1'b0;
    tick(5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h1234;
    #3;
    check("redir_pc_before", bus.pc, 64'h94);
    check("redir_valid", 64'(bus.instr_valid), 64'd0);
    check("redir_ready", 64'(bus.line_ready), 64'd1);
    tick(1);
    bus.redirect = 1'b0;
    offer(64'h1200, 32'h4000);
    push_line(64'h1200, 32'h4000, 13, 31);
    #3;
    check("redir_exp", bus.exp_pc, 64'h1200);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("offset_pc", bus.pc, 64'h1234);
    check("offset_instr", 64'(bus.instr), 64'h400D);
    tick(18); #3;
    check("offset_last_pc", bus.pc, 64'h127C);
    tick(1); #3;
    check("offset_done_valid", 64'(bus.instr_valid), 64'd0);
    check("offset_done_exp", bus.exp_pc, 64'h1280);

    // Backpressure at idx 3 with a pending line
    offer(64'h1280, 32'h5000);
    push_line(64'h1280, 32'h5000, 0, 31);
    tick(1);
    bus.line_valid = 1'b0;
    tick(3);
    bus.instr_ready = 1'b0;
    offer(64'h1300, 32'h9000);
    for (int i = 0; i < 4; i++) begin
      #3;
      check("bp_valid", 64'(bus.instr_valid), 64'd1);
      check("bp_pc", bus.pc, 64'h128C);
      check("bp_instr", 64'(bus.instr), 64'h5003);
      check("bp_line_ready", 64'(bus.line_ready), 64'd0);
      tick(1);
    end
    bus.instr_ready = 1'b1;
    bus.line_valid  = 1'b0;
    tick(29); #3;
    check("bp_done_valid", 64'(bus.instr_valid), 64'd0);
    check("bp_done_exp", bus.exp_pc, 64'h1300);

    // Wrap at top of address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FF80;
    tick(1);
    bus.redirect = 1'b0;
    offer(64'hFFFF_FFFF_FFFF_FF80, 32'h6000);
    push_line(64'hFFFF_FFFF_FFFF_FF80, 32'h6000, 0, 31);
    #3;
    check("wrap_setup_exp", bus.exp_pc, 64'hFFFF_FFFF_FFFF_FF80);
    tick(1);
    bus.line_valid = 1'b0;
    tick(32); #3;
    check("wrap_exp", bus.exp_pc, 64'h0);
    check("wrap_valid", 64'(bus.instr_valid), 64'd0);

    // Synchronous reset in the middle of line 0x1000 (entered at offset 2)
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h1008;
    tick(1);
    bus.redirect = 1'b0;
    offer(64'h1000, 32'h7000);
    push_line(64'h1000, 32'h7000, 2, 4);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("pre_rst_pc", bus.pc, 64'h1008);
    tick(3);
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #3;
    check("midrst_valid", 64'(bus.instr_valid), 64'd0);
    check("midrst_exp", bus.exp_pc, 64'h0);
    check("midrst_ready", 64'(bus.line_ready), 64'd1);
    check("midrst_stale", 64'(bus.stale), 64'd0);
    bus.instr_ready = 1'b1;
    offer(64'h0, 32'h8000);
    push_line(64'h0, 32'h8000, 0, 31);
    tick(1);
    bus.line_valid = 1'b0;
    #3;
    check("post_rst_pc", bus.pc, 64'h0);
    tick(32); #3;
    check("final_exp", bus.exp_pc, 64'h80);
    check("final_valid", 64'(bus.instr_valid), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
